// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU.
// Opcode enum is common with the ALU controller; the FSM state enum and the
// default datapath width live here too.
package alu_pkg;

   localparam int ALU_DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_XOR = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_SRA = 4'b0111,
      OP_SUB = 4'b1010,
      OP_SLT = 4'b1100,
      OP_BEQ = 4'b1000,
      OP_BNE = 4'b1001,
      OP_BLT = 4'b1110,
      OP_BGE = 4'b1011
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } exec_state_e;

   // True for the three shift opcodes, which take the shifter path.
   function automatic logic is_shift_op(input alu_op_e op);
      case (op)
         OP_SLL, OP_SRL, OP_SRA: is_shift_op = 1'b1;
         default:                is_shift_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: one-bit-per-cycle shifter used when ALU_BARREL_SHIFT_EN
// is not defined. Holds the work register, the remaining-shift counter and
// the direction/arithmetic selects captured at load time. 'last' flags the
// cycle whose step performs the final shift; 'next_data' is the value the
// work register takes on that step.
module alu_iter_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [SHAMT_W-1:0]    load_amt,
   input  logic                  shift_left,
   input  logic                  shift_arith,
   output logic [DATA_WIDTH-1:0] next_data,
   output logic                  last
);

   localparam logic [SHAMT_W-1:0] AMT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] work_r;
   logic [SHAMT_W-1:0]    count_r;
   logic                  left_r;
   logic                  arith_r;
   logic                  fill_s;

   assign last = (count_r == AMT_ONE);

   // Single-bit shift of the work register in the captured direction.
   always_comb begin
      fill_s    = arith_r & work_r[DATA_WIDTH-1];
      next_data = {DATA_WIDTH{1'b0}};
      if (left_r) begin
         next_data = {work_r[DATA_WIDTH-2:0], 1'b0};
      end else begin
         next_data = {fill_s, work_r[DATA_WIDTH-1:1]};
      end
   end

   // Load on accept, then shift and count down once per step.
   always_ff @(posedge clk) begin
      if (reset) begin
         work_r  <= {DATA_WIDTH{1'b0}};
         count_r <= {SHAMT_W{1'b0}};
         left_r  <= 1'b0;
         arith_r <= 1'b0;
      end else if (load) begin
         work_r  <= load_data;
         count_r <= load_amt;
         left_r  <= shift_left;
         arith_r <= shift_arith;
      end else if (step) begin
         work_r  <= next_data;
         count_r <= count_r - AMT_ONE;
      end else begin
         work_r  <= work_r;
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Non-shift ops complete in one cycle. Shifts are iterative (one bit per
// cycle) by default; defining ALU_BARREL_SHIFT_EN replaces the iterative
// shifter with a combinational barrel shifter and drops the SHIFT state.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
   parameter int OPCODE_LENGTH = 4,
   parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     BrTaken
);

   localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

   exec_state_e           state_r, state_nxt_s;
   logic [DATA_WIDTH-1:0] alu_result_r, result_nxt_s;
   logic                  br_taken_r, br_nxt_s;
   alu_op_e               op_s;
   logic [SHAMT_W-1:0]    shamt_s;
   logic                  accept_s;
   logic                  signed_lt_s;
   logic                  eq_s;
   logic [DATA_WIDTH-1:0] comb_result_s;
   logic                  comb_br_s;

   assign op_s        = alu_op_e'(Operation);
   assign shamt_s     = SrcB[SHAMT_W-1:0];
   assign signed_lt_s = ($signed(SrcA) < $signed(SrcB));
   assign eq_s        = (SrcA == SrcB);

   assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
   assign accept_s  = in_valid && in_ready;
   assign out_valid = (state_r == DONE);
   assign ALUResult = alu_result_r;
   assign BrTaken   = br_taken_r;

`ifdef ALU_BARREL_SHIFT_EN
   logic [DATA_WIDTH-1:0] barrel_s;

   // Full-width combinational shift for the single-cycle shift path.
   always_comb begin
      barrel_s = ZERO_W;
      case (op_s)
         OP_SLL:  barrel_s = SrcA << shamt_s;
         OP_SRL:  barrel_s = SrcA >> shamt_s;
         OP_SRA:  barrel_s = $unsigned($signed(SrcA) >>> shamt_s);
         default: barrel_s = ZERO_W;
      endcase
   end
`else
   logic [DATA_WIDTH-1:0] shift_next_s;
   logic                  shift_last_s;
   logic                  load_s;
   logic                  step_s;

   alu_iter_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W)
   ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .load        (load_s),
      .step        (step_s),
      .load_data   (SrcA),
      .load_amt    (shamt_s),
      .shift_left  (op_s == OP_SLL),
      .shift_arith (op_s == OP_SRA),
      .next_data   (shift_next_s),
      .last        (shift_last_s)
   );
`endif

   // Single-cycle arithmetic, logic, compare and branch results.
   always_comb begin
      comb_result_s = ZERO_W;
      comb_br_s     = 1'b0;
      case (op_s)
         OP_AND: comb_result_s = SrcA & SrcB;
         OP_OR:  comb_result_s = SrcA | SrcB;
         OP_XOR: comb_result_s = SrcA ^ SrcB;
         OP_ADD: comb_result_s = SrcA + SrcB;
         OP_SUB: comb_result_s = SrcA - SrcB;
         OP_SLT: comb_result_s = {{(DATA_WIDTH-1){1'b0}}, signed_lt_s};
         OP_BEQ: begin
            comb_br_s     = eq_s;
            comb_result_s = {{(DATA_WIDTH-1){1'b0}}, eq_s};
         end
         OP_BNE: begin
            comb_br_s     = ~eq_s;
            comb_result_s = {{(DATA_WIDTH-1){1'b0}}, ~eq_s};
         end
         OP_BLT: begin
            comb_br_s     = signed_lt_s;
            comb_result_s = {{(DATA_WIDTH-1){1'b0}}, signed_lt_s};
         end
         OP_BGE: begin
            comb_br_s     = ~signed_lt_s;
            comb_result_s = {{(DATA_WIDTH-1){1'b0}}, ~signed_lt_s};
         end
         default: begin
            comb_result_s = ZERO_W;
            comb_br_s     = 1'b0;
         end
      endcase
   end

   // Next-state and next-result selection; results only move on DONE entry.
   always_comb begin
      state_nxt_s  = state_r;
      result_nxt_s = alu_result_r;
      br_nxt_s     = br_taken_r;
`ifndef ALU_BARREL_SHIFT_EN
      load_s       = 1'b0;
      step_s       = 1'b0;
`endif
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               state_nxt_s = DONE;
               if (is_shift_op(op_s)) begin
                  br_nxt_s = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
                  result_nxt_s = barrel_s;
`else
                  if (shamt_s == {SHAMT_W{1'b0}}) begin
                     result_nxt_s = SrcA;
                  end else begin
                     load_s      = 1'b1;
                     state_nxt_s = SHIFT;
                  end
`endif
               end else begin
                  result_nxt_s = comb_result_s;
                  br_nxt_s     = comb_br_s;
               end
            end else if ((state_r == DONE) && out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
`ifndef ALU_BARREL_SHIFT_EN
         SHIFT: begin
            step_s = 1'b1;
            if (shift_last_s) begin
               state_nxt_s  = DONE;
               result_nxt_s = shift_next_s;
               br_nxt_s     = 1'b0;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         alu_result_r <= ZERO_W;
         br_taken_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         alu_result_r <= result_nxt_s;
         br_taken_r   <= br_nxt_s;
      end
   end

endmodule
